// File: rtl/threshold_config_sequencer.sv
// threshold_config_sequencer: command-driven write/read/broadcast/verify sequencer for the threshold bank
module threshold_config_sequencer #(
    parameter int N_CH     = 40,
    parameter int CH_W     = 8,
    parameter int THR_W    = 32,
    parameter int READ_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CH_W-1:0]  cmd_ch,
    input  logic [THR_W-1:0] cmd_value,
    output logic             rsp_valid,
    output logic [THR_W-1:0] rsp_value,
    output logic             rsp_error,
    output logic [CH_W-1:0]  rsp_err_ch,
    output logic             busy,
    output logic             thr_write,
    output logic [CH_W-1:0]  thr_ch,
    output logic [THR_W-1:0] thr_value,
    input  logic [THR_W-1:0] thr_read_value
);
    localparam int LW = $clog2(READ_LAT + 1);
    typedef enum logic [2:0] {IDLE, WR, BWR, RD, VFY, RESP} state_t;
    state_t state, state_d;
    logic [THR_W-1:0] val, val_d, rsp_value_d, thr_value_d;
    logic [LW-1:0] lat, lat_d;
    logic [CH_W-1:0] rsp_err_ch_d, thr_ch_d;
    logic rsp_valid_d, rsp_error_d, thr_write_d;
    logic last_ch, last_lat;
    assign last_ch  = thr_ch == CH_W'(N_CH - 1);
    assign last_lat = lat == LW'(READ_LAT - 1);
    always_comb begin
        state_d      = state;
        val_d        = val;
        lat_d        = lat;
        rsp_valid_d  = 1'b0;
        rsp_value_d  = rsp_value;
        rsp_error_d  = rsp_error;
        rsp_err_ch_d = rsp_err_ch;
        thr_write_d  = 1'b0;
        thr_ch_d     = thr_ch;
        thr_value_d  = thr_value;
        case (state)
            IDLE: if (cmd_valid && cmd_ready) begin
                val_d = cmd_value;
                lat_d = '0;
                if (!cmd_op[1] && cmd_ch >= CH_W'(N_CH)) begin
                    state_d      = RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_error_d  = 1'b1;
                    rsp_err_ch_d = cmd_ch;
                    rsp_value_d  = '0;
                end else begin
                    state_d     = cmd_op == 2'b00 ? WR : cmd_op == 2'b01 ? RD : cmd_op == 2'b10 ? BWR : VFY;
                    thr_write_d = !cmd_op[0];
                    thr_ch_d    = cmd_op[1] ? '0 : cmd_ch;
                    thr_value_d = cmd_op[0] ? thr_value : cmd_value;
                end
            end
            WR: begin
                state_d      = RESP;
                rsp_valid_d  = 1'b1;
                rsp_error_d  = 1'b0;
                rsp_err_ch_d = '0;
                rsp_value_d  = val;
            end
            RD: if (last_lat) begin
                state_d      = RESP;
                rsp_valid_d  = 1'b1;
                rsp_error_d  = 1'b0;
                rsp_err_ch_d = '0;
                rsp_value_d  = thr_read_value;
            end else lat_d = lat + 1'b1;
            BWR: if (last_ch) begin
                state_d      = RESP;
                rsp_valid_d  = 1'b1;
                rsp_error_d  = 1'b0;
                rsp_err_ch_d = '0;
                rsp_value_d  = val;
            end else begin
                thr_write_d = 1'b1;
                thr_ch_d    = thr_ch + 1'b1;
            end
            VFY: if (!last_lat) lat_d = lat + 1'b1;
            else if ($signed(thr_read_value) != $signed(val) || last_ch) begin
                // first mismatch wins; otherwise the final channel closes a clean pass
                state_d      = RESP;
                rsp_valid_d  = 1'b1;
                rsp_error_d  = $signed(thr_read_value) != $signed(val);
                rsp_err_ch_d = rsp_error_d ? thr_ch : '0;
                rsp_value_d  = rsp_error_d ? thr_read_value : val;
            end else begin
                thr_ch_d = thr_ch + 1'b1;
                lat_d    = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            val        <= '0;
            lat        <= '0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_value  <= '0;
            rsp_error  <= 1'b0;
            rsp_err_ch <= '0;
            thr_write  <= 1'b0;
            thr_ch     <= '0;
            thr_value  <= '0;
        end else begin
            state      <= state_d;
            val        <= val_d;
            lat        <= lat_d;
            cmd_ready  <= state_d == IDLE;
            busy       <= state_d != IDLE;
            rsp_valid  <= rsp_valid_d;
            rsp_value  <= rsp_value_d;
            rsp_error  <= rsp_error_d;
            rsp_err_ch <= rsp_err_ch_d;
            thr_write  <= thr_write_d;
            thr_ch     <= thr_ch_d;
            thr_value  <= thr_value_d;
        end
    end
endmodule

// File: tb/tb_threshold_config_sequencer.sv
// tb_threshold_config_sequencer: directed bench with a registered threshold-bank model
module tb_threshold_config_sequencer;
    logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
    logic [1:0] cmd_op = '0;
    logic [7:0] cmd_ch = '0;
    logic [31:0] cmd_value = '0, thr_read_value = '0;
    logic cmd_ready, rsp_valid, rsp_error, busy, thr_write;
    logic [31:0] rsp_value, thr_value;
    logic [7:0] rsp_err_ch, thr_ch;
    logic [31:0] mem [40];
    logic [7:0] wlog [256];
    int wr_cnt = 0, rsp_cnt = 0, acc_cnt = 0, rb_cnt = 0;
    int n_chk = 0, n_pass = 0, n_fail = 0;

    threshold_config_sequencer dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_value(cmd_value),
        .rsp_valid(rsp_valid), .rsp_value(rsp_value), .rsp_error(rsp_error),
        .rsp_err_ch(rsp_err_ch), .busy(busy), .thr_write(thr_write),
        .thr_ch(thr_ch), .thr_value(thr_value), .thr_read_value(thr_read_value)
    );

    always #5 clk = ~clk;

    // datapath: write on edge, registered read one cycle after thr_ch
    always @(posedge clk) begin
        if (thr_write) begin
            if (thr_ch < 8'd40) mem[thr_ch] <= thr_value;
        end else thr_read_value <= (thr_ch < 8'd40) ? mem[thr_ch] : 32'hdead_beef;
    end

    always @(negedge clk) begin
        if (thr_write) begin
            if (wr_cnt < 256) wlog[wr_cnt] = thr_ch;
            wr_cnt++;
        end
        if (rsp_valid) rsp_cnt++;
        if (cmd_valid && cmd_ready) acc_cnt++;
        if (cmd_ready && busy) rb_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // leaves the bench 1ns into cycle 1
    task automatic issue(input logic [1:0] op, input logic [7:0] ch, input logic [31:0] v, input logic hold);
        int k = 0;
        while (!cmd_ready && k < 200) begin tick(); k++; end
        chk("ready_wait", 32'(cmd_ready), 32'd1);
        cmd_op = op; cmd_ch = ch; cmd_value = v; cmd_valid = 1'b1;
        tick();
        cmd_valid = hold;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 200) begin tick(); lat++; end
    endtask

    initial begin
        int lat, w0, r0, a0, bad;
        repeat (3) tick();
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_thr_write", 32'(thr_write), 0);
        reset = 1'b0;
        tick();
        chk("ready_after_rst", 32'(cmd_ready), 1);

        // single write then read back
        w0 = wr_cnt;
        issue(2'b00, 8'd5, -32'sd1200, 1'b0);
        chk("wr_thr_write", 32'(thr_write), 1);
        chk("wr_thr_ch", 32'(thr_ch), 5);
        chk("wr_thr_value", thr_value, -32'sd1200);
        chk("wr_busy", 32'(busy), 1);
        wait_rsp(lat);
        chk("wr_lat", 32'(lat), 2);
        chk("wr_err", 32'(rsp_error), 0);
        chk("wr_value", rsp_value, -32'sd1200);
        tick();
        chk("wr_ready_next", 32'(cmd_ready), 1);
        chk("wr_count", 32'(wr_cnt - w0), 1);
        issue(2'b01, 8'd5, 32'd0, 1'b0);
        chk("rd_no_write", 32'(thr_write), 0);
        wait_rsp(lat);
        chk("rd_lat", 32'(lat), 3);
        chk("rd_value", rsp_value, -32'sd1200);
        chk("rd_err", 32'(rsp_error), 0);
        tick();

        // broadcast with cmd_valid held high the whole time
        w0 = wr_cnt; r0 = rsp_cnt; a0 = acc_cnt;
        issue(2'b10, 8'd0, 32'd777, 1'b1);
        cmd_op = 2'b00; cmd_ch = 8'd23; cmd_value = 32'd5;
        chk("bwr_ready_low", 32'(cmd_ready), 0);
        wait_rsp(lat);
        cmd_valid = 1'b0;
        chk("bwr_lat", 32'(lat), 41);
        chk("bwr_value", rsp_value, 32'd777);
        chk("bwr_err", 32'(rsp_error), 0);
        tick();
        chk("bwr_ready_next", 32'(cmd_ready), 1);
        chk("bwr_write_count", 32'(wr_cnt - w0), 40);
        bad = 0;
        for (int i = 0; i < 40; i++) if (wlog[w0 + i] != 8'(i)) bad++;
        chk("bwr_ch_seq", 32'(bad), 0);
        chk("bwr_accepts", 32'(acc_cnt - a0), 1);
        chk("bwr_rsp_count", 32'(rsp_cnt - r0), 1);

        // clean verify
        issue(2'b11, 8'd0, 32'd777, 1'b0);
        wait_rsp(lat);
        chk("vfy_lat", 32'(lat), 81);
        chk("vfy_err", 32'(rsp_error), 0);
        chk("vfy_err_ch", 32'(rsp_err_ch), 0);
        chk("vfy_value", rsp_value, 32'd777);
        tick();

        // corrupt ch 23 then verify
        issue(2'b00, 8'd23, 32'd5, 1'b0);
        wait_rsp(lat);
        tick();
        issue(2'b11, 8'd0, 32'd777, 1'b0);
        wait_rsp(lat);
        chk("mis_lat", 32'(lat), 49);
        chk("mis_err", 32'(rsp_error), 1);
        chk("mis_err_ch", 32'(rsp_err_ch), 23);
        chk("mis_value", rsp_value, 32'd5);
        tick();

        // out-of-range channels
        w0 = wr_cnt;
        issue(2'b01, 8'd40, 32'd0, 1'b0);
        chk("bad_rd_rsp", 32'(rsp_valid), 1);
        chk("bad_rd_err", 32'(rsp_error), 1);
        chk("bad_rd_err_ch", 32'(rsp_err_ch), 40);
        chk("bad_rd_value", rsp_value, 0);
        tick();
        tick();
        issue(2'b00, 8'd255, 32'd99, 1'b0);
        chk("bad_wr_rsp", 32'(rsp_valid), 1);
        chk("bad_wr_err", 32'(rsp_error), 1);
        chk("bad_wr_err_ch", 32'(rsp_err_ch), 255);
        tick();
        chk("bad_ready_next", 32'(cmd_ready), 1);
        chk("bad_no_write", 32'(wr_cnt - w0), 0);

        // reset in cycle 10 of a broadcast
        r0 = rsp_cnt;
        issue(2'b10, 8'd0, 32'd999, 1'b0);
        repeat (9) tick();
        chk("pre_rst_ch", 32'(thr_ch), 9);
        reset = 1'b1;
        #1;
        chk("mid_rst_thr_write", 32'(thr_write), 0);
        chk("mid_rst_thr_ch", 32'(thr_ch), 0);
        chk("mid_rst_thr_value", thr_value, 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_rsp_err", 32'(rsp_error), 0);
        chk("mid_rst_rsp_err_ch", 32'(rsp_err_ch), 0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();
        chk("post_rst_ready", 32'(cmd_ready), 1);
        chk("post_rst_busy", 32'(busy), 0);
        chk("rst_no_rsp", 32'(rsp_cnt - r0), 0);
        bad = 0;
        for (int i = 0; i < 9; i++) if (mem[i] != 32'd999) bad++;
        chk("rst_mem_0_8", 32'(bad), 0);
        chk("rst_mem_9", mem[9], 32'd777);
        issue(2'b01, 8'd8, 32'd0, 1'b0);
        wait_rsp(lat);
        chk("rst_rd8_value", rsp_value, 32'd999);
        tick();
        chk("ready_never_busy", 32'(rb_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
